// File: rtl/pc_sequencer.sv
// Fetch-address sequencer. It increments the PC, loads redirect targets from the
// execute stage (deferring them across stalls), sequences pipeline flushes and halts.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        halt_i,
    input  logic        ex_valid_i,
    input  logic [1:0]  branch_type_i,
    input  logic        branch_dec_i,
    input  logic [31:0] target_i,
    output logic [31:0] pc_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic        halted_o
);

    typedef enum logic [1:0] {
        RUN,
        PEND,
        FLUSH,
        HALT
    } state_t;

    localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [2:0]  flush_cnt;
    logic [31:0] target_buf;

    logic        taken;
    logic [31:0] load_target;
    logic [31:0] pc_inc;

    // Jump (10) and jump-register (11) share bit 1; a conditional branch (01) needs the outcome.
    assign taken       = ex_valid_i & (branch_type_i[1] | (branch_type_i[0] & branch_dec_i));
    assign load_target = {target_i[31:2], 2'b00};
    assign pc_inc      = pc_o + 32'd4;

    // NOTE: every register here uses non-blocking assignments, so all next-state
    // decisions in this block see the values from before the clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RUN;
            pc_o       <= RESET_PC;
            flush_o    <= 1'b0;
            redirect_o <= 1'b0;
            halted_o   <= 1'b0;
            flush_cnt  <= 3'd0;
            target_buf <= 32'd0;
        end else begin
            // NOTE: redirect_o is cleared by default so it can only ever be a one-cycle pulse.
            redirect_o <= 1'b0;
            case (state)
                RUN: begin
                    if (taken) begin
                        if (!stall_i) begin
                            pc_o       <= load_target;
                            redirect_o <= 1'b1;
                            flush_o    <= 1'b1;
                            flush_cnt  <= FLUSH_INIT;
                            state      <= FLUSH;
                        end else begin
                            target_buf <= load_target;
                            state      <= PEND;
                        end
                    end else if (halt_i) begin
                        halted_o <= 1'b1;
                        state    <= HALT;
                    end else if (!stall_i) begin
                        pc_o <= pc_inc;
                    end
                end

                PEND: begin
                    if (stall_i) begin
                        if (taken) begin
                            target_buf <= load_target;
                        end
                    end else begin
                        pc_o       <= target_buf;
                        redirect_o <= 1'b1;
                        flush_o    <= 1'b1;
                        flush_cnt  <= FLUSH_INIT;
                        state      <= FLUSH;
                    end
                end

                FLUSH: begin
                    // Younger stages are being killed, so execute-stage requests are not trusted here.
                    if (!stall_i) begin
                        pc_o <= pc_inc;
                        if (flush_cnt == 3'd0) begin
                            flush_o <= 1'b0;
                            state   <= RUN;
                        end else begin
                            flush_cnt <= flush_cnt - 3'd1;
                        end
                    end
                end

                HALT: begin
                    flush_o <= 1'b0;
                end

                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

endmodule
